// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample width, stereo pair type, frame length.
package audio_pkg;
   localparam int SAMPLE_BITS = 16;
   localparam int MCLK_PER_FS = 256;

   typedef struct packed {
      shortint l;
      shortint r;
   } stereo_sample_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing: mclk divider and slot-bit counter, with registered bclk/lrclk.
// bclk/lrclk are registered from next-state counters, so they always decode the current counters.
module i2s_clk_gen #(
   parameter  int MCLK_DIV  = 4,
   parameter  int SLOT_BITS = 32,
   localparam int BW        = $clog2(2*SLOT_BITS)
) (
   input  logic          mclk,
   input  logic          rst,
   output logic          bclk,
   output logic          lrclk,
   output logic          boundary,
   output logic [BW-1:0] bit_idx
);
   localparam int DW = $clog2(MCLK_DIV);
   localparam logic [DW-1:0] DIV_MAX  = DW'(MCLK_DIV-1);
   localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_DIV/2);
   localparam logic [BW-1:0] BIT_MAX  = BW'(2*SLOT_BITS-1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

   logic [DW-1:0] div_cnt, div_nxt;
   logic [BW-1:0] bit_cnt, bit_nxt;

   always_comb begin
      div_nxt = div_cnt + 1'b1;
      bit_nxt = bit_cnt;
      if (div_cnt == DIV_MAX) begin
         div_nxt = '0;
         bit_nxt = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
      end
   end

   assign boundary = (div_cnt == DIV_MAX) && (bit_cnt == BIT_MAX);
   // Index that becomes current next cycle; lets the top register sdata in step with it.
   assign bit_idx  = bit_nxt;

   always_ff @(posedge mclk) begin
      if (rst) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk    <= 1'b0;
         lrclk   <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         bclk    <= (div_nxt >= DIV_HALF);
         lrclk   <= (bit_nxt >= SLOT);
      end
   end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo sample sink that serialises pairs onto an I2S link; one active pair plus one holding slot.
// Optional I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_tx_serializer #(
   parameter int SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
   parameter int SLOT_BITS   = 32,
   parameter int MCLK_DIV    = 4
) (
   input  logic                   mclk,
   input  logic                   rst,
   input  logic [SAMPLE_BITS-1:0] s_sample_l,
   input  logic [SAMPLE_BITS-1:0] s_sample_r,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   bclk,
   output logic                   lrclk,
   output logic                   sdata,
   output logic                   frame_start,
`ifdef I2S_TX_UNDERRUN_CNT_EN
   output logic [15:0]            underrun_count,
`endif
   output logic                   underrun
);
   localparam int BW = $clog2(2*SLOT_BITS);
   localparam int SW = $clog2(SAMPLE_BITS);

   logic                   boundary;
   logic [BW-1:0]          bit_idx;
   logic [SAMPLE_BITS-1:0] hold_l, hold_r, active_l, active_r;
   logic                   hold_full;
   logic                   sdata_nxt;
   logic [SW-1:0]          sel;
   int                     b;

   i2s_clk_gen #(.MCLK_DIV(MCLK_DIV), .SLOT_BITS(SLOT_BITS)) u_clk_gen (
      .mclk     (mclk),
      .rst      (rst),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .boundary (boundary),
      .bit_idx  (bit_idx)
   );

   assign s_ready = !hold_full;

   // The current active pair is safe here: at a boundary the next index is 0, which is padding.
   always_comb begin
      b         = int'(bit_idx);
      sel       = '0;
      sdata_nxt = 1'b0;
      if (b >= 1 && b <= SAMPLE_BITS) begin
         sel       = SW'(SAMPLE_BITS - b);
         sdata_nxt = active_l[sel];
      end else if (b >= SLOT_BITS + 1 && b <= SLOT_BITS + SAMPLE_BITS) begin
         sel       = SW'(SLOT_BITS + SAMPLE_BITS - b);
         sdata_nxt = active_r[sel];
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         hold_l      <= '0;
         hold_r      <= '0;
         active_l    <= '0;
         active_r    <= '0;
         hold_full   <= 1'b0;
         sdata       <= 1'b0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         sdata       <= sdata_nxt;
         frame_start <= boundary;
         underrun    <= boundary && !hold_full;
         if (boundary) begin
            active_l  <= hold_full ? hold_l : '0;
            active_r  <= hold_full ? hold_r : '0;
            hold_full <= 1'b0;
         end
         // An accept in a boundary cycle lands in hold; the muted frame still goes out.
         if (s_valid && s_ready) begin
            hold_l    <= s_sample_l;
            hold_r    <= s_sample_r;
            hold_full <= 1'b1;
         end
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge mclk) begin
      if (rst)
         underrun_count <= '0;
      else if (boundary && !hold_full && underrun_count != 16'hFFFF)
         underrun_count <= underrun_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomised and directed bench for i2s_tx_serializer against a cycle-count/queue model.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;
   import audio_pkg::*;

   localparam int FRAME = MCLK_PER_FS;

   logic        mclk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_sample_l = '0, s_sample_r = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, bclk, lrclk, sdata, frame_start, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [15:0] underrun_count;
`endif

   i2s_tx_serializer dut (
      .mclk           (mclk),
      .rst            (rst),
      .s_sample_l     (s_sample_l),
      .s_sample_r     (s_sample_r),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .bclk           (bclk),
      .lrclk          (lrclk),
      .sdata          (sdata),
      .frame_start    (frame_start),
`ifdef I2S_TX_UNDERRUN_CNT_EN
      .underrun_count (underrun_count),
`endif
      .underrun       (underrun)
   );

   always #5 mclk = ~mclk;

   int checks = 0, errors = 0;

   // Model: t = cycles since reset release, a queue of at most one pending pair, the pair on air.
   int             t = 0;
   stereo_sample_t act = '0;
   stereo_sample_t q[$];
   bit             m_fs = 0, m_ur = 0;
   int             m_ucnt = 0;
   int             dut_acc = 0, fs_seen = 0, ur_seen = 0, first_fs = -1;
   logic [15:0]    cap_l = '0, cap_r = '0;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h expected %0h at t=%0d", nm, a, e, t);
      end
   endtask

   function automatic bit exp_sdata();
      int          bi = (t / 4) % 64;
      logic [15:0] l = act.l;
      logic [15:0] r = act.r;
      if (bi >= 1 && bi <= 16)  return l[16 - bi];
      if (bi >= 33 && bi <= 48) return r[48 - bi];
      return 1'b0;
   endfunction

   task automatic step();
      bit             acc;
      stereo_sample_t p;
      if (!rst && s_valid && s_ready) dut_acc++;
      @(posedge mclk);
      acc = s_valid && (q.size() == 0);
      if (rst) begin
         t = 0; act = '0; q.delete(); m_fs = 0; m_ur = 0; m_ucnt = 0; first_fs = -1;
      end else begin
         m_fs = 0; m_ur = 0;
         if (t % FRAME == FRAME - 1) begin
            m_fs = 1;
            if (q.size() > 0) act = q.pop_front();
            else begin
               act = '0; m_ur = 1;
               if (m_ucnt < 65535) m_ucnt++;
            end
         end
         if (acc) begin
            p.l = s_sample_l; p.r = s_sample_r;
            q.push_back(p);
         end
         t++;
      end
      @(negedge mclk);
      chk("bclk",        bclk,        32'((t % 4) >= 2));
      chk("lrclk",       lrclk,       32'(((t / 4) % 64) >= 32));
      chk("sdata",       sdata,       32'(exp_sdata()));
      chk("s_ready",     s_ready,     32'(q.size() == 0));
      chk("frame_start", frame_start, 32'(m_fs));
      chk("underrun",    underrun,    32'(m_ur));
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("underrun_count", underrun_count, 32'(m_ucnt));
`endif
      if (t % 4 == 2) begin
         if (((t / 4) % 64) >= 1  && ((t / 4) % 64) <= 16) cap_l = {cap_l[14:0], sdata};
         if (((t / 4) % 64) >= 33 && ((t / 4) % 64) <= 48) cap_r = {cap_r[14:0], sdata};
      end
      if (frame_start) fs_seen++;
      if (underrun) ur_seen++;
      if (frame_start && first_fs < 0 && !rst) first_fs = t;
   endtask

   task automatic run_to(input int phase);
      for (int i = 0; i < FRAME + 1 && (t % FRAME) != phase; i++) step();
   endtask

   logic [15:0] cnt;
   int          ur0;

   initial begin
      // Reset and idle: silent frames, underrun each frame, first frame_start 256 after release.
      for (int i = 0; i < 3; i++) step();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_bclk", bclk, 0);
      rst = 1'b0;
      ur_seen = 0;
      for (int i = 0; i < 3*FRAME + 10; i++) step();
      chk("first_fs", first_fs, 256);
      chk("idle_underruns", ur_seen, 3);

      // Directed pair: MSB one bclk after the lrclk edge, zero padding after LSB.
      run_to(100);
      s_sample_l = 16'h8001; s_sample_r = 16'h7FFE; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      run_to(0);
      chk("load_fs", frame_start, 1);
      chk("load_ur", underrun, 0);
      run_to(FRAME - 1);
      chk("cap_l_8001", cap_l, 32'b1000_0000_0000_0001);
      chk("cap_r_7ffe", cap_r, 32'b0111_1111_1111_1110);

      // Offer in the exact boundary cycle with hold empty: this frame muted, next carries it.
      s_sample_l = 16'hA5C3; s_sample_r = 16'h3C5A; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      chk("bnd_ur", underrun, 1);
      chk("bnd_fs", frame_start, 1);
      chk("bnd_s_ready", s_ready, 0);
      run_to(FRAME - 1);
      step();
      run_to(FRAME - 1);
      chk("bnd_cap_l", cap_l, 32'hA5C3);
      chk("bnd_cap_r", cap_r, 32'h3C5A);
      step();

      // Continuous valid: exactly one pair consumed per frame, in order.
      cnt = 16'h0100;
      s_sample_l = cnt; s_sample_r = ~cnt; s_valid = 1'b1;
      dut_acc = 0;
      for (int i = 0; i < 4*FRAME; i++) begin
         bit pre = s_valid && s_ready;
         step();
         if (pre) begin
            cnt = cnt + 16'd1;
            s_sample_l = cnt; s_sample_r = ~cnt;
         end
      end
      chk("stream_accepts", dut_acc, 4);
      s_valid = 1'b0;

      // Random offers, random data churn.
      for (int i = 0; i < 12*FRAME; i++) begin
         s_valid    = ($urandom_range(0, 199) == 0);
         s_sample_l = 16'($urandom);
         s_sample_r = 16'($urandom);
         step();
      end
      s_valid = 1'b0;

      // Reset mid right slot (bit 40) with hold full.
      run_to(150);
      s_sample_l = 16'h1234; s_sample_r = 16'h5678; s_valid = 1'b1;
      for (int i = 0; i < 300 && s_ready !== 1'b0; i++) step();
      s_valid = 1'b0;
      run_to(160);
      chk("pre_rst_s_ready", s_ready, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_bclk", bclk, 0);
      chk("mid_rst_lrclk", lrclk, 0);
      chk("mid_rst_sdata", sdata, 0);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_fs", frame_start, 0);
      chk("mid_rst_ur", underrun, 0);

      // Five silent frames after reset.
      ur0 = ur_seen;
      for (int i = 0; i < 5*FRAME + 2; i++) step();
      chk("post_rst_first_fs", first_fs, 256);
      chk("post_rst_underruns", ur_seen - ur0, 5);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("ucnt_5", underrun_count, 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ucnt_clr", underrun_count, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
